// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-image loader.
package program_loader_pkg;

    typedef enum logic [1:0] {HDR, DATA, WRITE, DONE} loader_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int HDR_BYTES          = 4;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word shifter; word/word_complete describe the word that the
// current shift would finish, so the caller can register it on the same edge.
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BYTES      = BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [7:0]            byte_data,
    input  logic                  shift_en,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_complete
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0] count_reg;

    assign word_complete = shift_en && (count_reg == CNT_W'(BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear || word_complete) begin
            count_reg <= '0;
        end else if (shift_en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign word[7:0] = byte_data;

    generate
        if (BYTES > 1) begin : g_lanes
            // lane_reg[0] holds the most recent byte; the oldest byte ends up on top
            logic [7:0] lane_reg [BYTES-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < BYTES - 1; i++) lane_reg[i] <= '0;
                end else if (clear) begin
                    for (int i = 0; i < BYTES - 1; i++) lane_reg[i] <= '0;
                end else if (shift_en) begin
                    lane_reg[0] <= byte_data;
                    for (int i = 1; i < BYTES - 1; i++) lane_reg[i] <= lane_reg[i-1];
                end
            end

            for (genvar gi = 0; gi < BYTES - 1; gi++) begin : g_word
                assign word[8*gi+15 -: 8] = lane_reg[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that writes an instruction image through the
// processor's init port, then releases it with a load_done pulse.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in_data,
    input  logic                     byte_in_valid,
    output logic                     byte_in_ready,
    input  logic                     load_abort,
    output logic [ADDRESS_WIDTH-1:0] ram_init_wadrs,
    output logic [DATA_WIDTH-1:0]    ram_write_instruction,
    output logic                     initialize_instructions,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_error
);

    localparam int          CW        = ADDRESS_WIDTH + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_WIDTH;

    loader_state_t            state_reg, state_next;
    logic [1:0]               hdr_cnt_reg, hdr_cnt_next;
    logic [23:0]              hdr_reg, hdr_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic [CW-1:0]            remaining_reg, remaining_next;
    logic [ADDRESS_WIDTH-1:0] wadrs_reg, wadrs_next;
    logic [DATA_WIDTH-1:0]    wdata_reg, wdata_next;
    logic                     init_reg, init_next;
    logic                     busy_reg, busy_next;
    logic                     ready_reg, ready_next;
    logic                     done_reg, done_next;
    logic                     error_reg, error_next;

    logic                     accept;
    logic [15:0]              hdr_count;
    logic [DATA_WIDTH-1:0]    word;
    logic                     word_complete;

    // Abort wins over the stream, so it also blocks the handshake combinationally
    assign byte_in_ready = ready_reg & ~load_abort;
    assign accept        = byte_in_valid & byte_in_ready;
    assign hdr_count     = {hdr_reg[7:0], byte_in_data};

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES      (DATA_WIDTH / 8)
    ) u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (load_abort),
        .byte_data     (byte_in_data),
        .shift_en      (accept && (state_reg == DATA)),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= HDR;
            hdr_cnt_reg   <= '0;
            hdr_reg       <= '0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            wadrs_reg     <= '0;
            wdata_reg     <= '0;
            init_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hdr_cnt_reg   <= hdr_cnt_next;
            hdr_reg       <= hdr_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            wadrs_reg     <= wadrs_next;
            wdata_reg     <= wdata_next;
            init_reg      <= init_next;
            busy_reg      <= busy_next;
            ready_reg     <= ready_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hdr_cnt_next   = hdr_cnt_reg;
        hdr_next       = hdr_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        wadrs_next     = wadrs_reg;
        wdata_next     = wdata_reg;
        init_next      = init_reg;
        done_next      = 1'b0;
        error_next     = 1'b0;

        if (load_abort) begin
            state_next     = HDR;
            hdr_cnt_next   = '0;
            addr_next      = '0;
            remaining_next = '0;
            init_next      = 1'b0;
        end else begin
            case (state_reg)
                HDR: begin
                    if (accept) begin
                        hdr_next = {hdr_reg[15:0], byte_in_data};
                        if (hdr_cnt_reg == 2'(HDR_BYTES - 1)) begin
                            hdr_cnt_next = '0;
                            if ((hdr_count == 16'd0) || ({1'b0, hdr_count} > MAX_WORDS)) begin
                                error_next = 1'b1;
                            end else begin
                                addr_next      = ADDRESS_WIDTH'(hdr_reg[23:8]);
                                remaining_next = CW'(hdr_count);
                                state_next     = DATA;
                            end
                        end else begin
                            hdr_cnt_next = hdr_cnt_reg + 2'd1;
                        end
                    end
                end
                DATA: begin
                    // Output registers load on the completing edge so the WRITE cycle already shows the word
                    if (word_complete) begin
                        wadrs_next = addr_reg;
                        wdata_next = word;
                        init_next  = 1'b1;
                        state_next = WRITE;
                    end
                end
                WRITE: begin
                    addr_next      = addr_reg + ADDRESS_WIDTH'(1);
                    remaining_next = remaining_reg - CW'(1);
                    if (remaining_reg == CW'(1)) begin
                        state_next = DONE;
                        init_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = DATA;
                    end
                end
                DONE: begin
                    state_next = HDR;
                end
                default: begin
                    state_next = HDR;
                end
            endcase
        end

        busy_next  = (state_next != HDR) || (hdr_cnt_next != 2'd0);
        ready_next = (state_next == HDR) || (state_next == DATA);
    end

    assign ram_init_wadrs          = wadrs_reg;
    assign ram_write_instruction   = wdata_reg;
    assign initialize_instructions = init_reg;
    assign busy                    = busy_reg;
    assign load_done               = done_reg;
    assign load_error              = error_reg;

endmodule
